// File: rtl/pe_array_pkg.sv
// Shared PE-array definitions: psum beat geometry, enable-bit position and
// the output-register state type used by the psum bus arbiter.
package pe_array_pkg;

  localparam int PSUM_DATA_SIZE = 32;
  localparam int OPSUM_NUM      = 4;

  // The enable (valid) bit of a psum bus beat sits this many bits below the MSB.
  localparam int PSUM_EN_FROM_MSB = 0;

  typedef enum logic [0:0] {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

  function automatic int psum_bus_w(input int opsum_num, input int data_size);
    return opsum_num * data_size + 1;
  endfunction

endpackage

// File: rtl/psum_bus_arbiter_rr.sv
// Combinational round-robin search: the first requester at or after ptr
// (wrapping modulo N) wins and is reported one-hot and as an index.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             any_req
);

  // Scan from ptr upward; the first hit locks the result for the rest of the loop.
  always_comb begin
    logic [IDX_W-1:0] idx_s;
    gnt     = '0;
    gnt_idx = '0;
    any_req = 1'b0;
    idx_s   = '0;
    for (int k = 0; k < N; k++) begin
      idx_s = IDX_W'((int'(ptr) + k) % N);
      if (!any_req && req[idx_s]) begin
        gnt[idx_s] = 1'b1;
        gnt_idx    = idx_s;
        any_req    = 1'b1;
      end else begin
        gnt[idx_s] = gnt[idx_s];
      end
    end
  end

endmodule

// File: rtl/psum_bus_arbiter.sv
// Shares one GLB psum write port among NUM_COL LN columns: masked round-robin
// grant into a one-entry output register with a valid/ready drain to the GLB.
module psum_bus_arbiter #(
  parameter int NUM_COL        = 4,
  parameter int PSUM_DATA_SIZE = pe_array_pkg::PSUM_DATA_SIZE,
  parameter int OPSUM_NUM      = pe_array_pkg::OPSUM_NUM,
  parameter int COL_ID_W       = $clog2(NUM_COL)
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic                                              set_info,
  input  logic [NUM_COL-1:0]                                col_mask,
  input  logic [NUM_COL*(OPSUM_NUM*PSUM_DATA_SIZE+1)-1:0]   opsum_bus,
  output logic [NUM_COL-1:0]                                opsum_ready_bus,
  output logic [OPSUM_NUM*PSUM_DATA_SIZE:0]                 glb_psum,
  output logic [COL_ID_W-1:0]                               glb_col_id,
  input  logic                                              glb_ready,
  output logic                                              busy
);

  import pe_array_pkg::*;

  localparam int BEAT_W = psum_bus_w(OPSUM_NUM, PSUM_DATA_SIZE);
  localparam int EN_BIT = BEAT_W - 1 - PSUM_EN_FROM_MSB;
  localparam int DATA_W = BEAT_W - 1;

  logic [NUM_COL-1:0]  mask_r;
  logic [COL_ID_W-1:0] rr_ptr_r;
  out_state_e          out_state_r;
  out_state_e          out_state_nxt_s;

  logic [BEAT_W-1:0]   beat_s [NUM_COL];
  logic [NUM_COL-1:0]  req_s;
  logic [NUM_COL-1:0]  gnt_s;
  logic [COL_ID_W-1:0] gnt_idx_s;
  logic                any_req_s;
  logic                can_load_s;
  logic                xfer_s;
  logic [COL_ID_W-1:0] ptr_nxt_s;
  logic [DATA_W-1:0]   win_data_s;

  for (genvar gi = 0; gi < NUM_COL; gi++) begin : g_slice
    assign beat_s[gi] = opsum_bus[gi*BEAT_W +: BEAT_W];
    assign req_s[gi]  = beat_s[gi][EN_BIT] & mask_r[gi];
  end

  rr_arbiter #(
    .N     (NUM_COL),
    .IDX_W (COL_ID_W)
  ) u_rr (
    .req     (req_s),
    .ptr     (rr_ptr_r),
    .gnt     (gnt_s),
    .gnt_idx (gnt_idx_s),
    .any_req (any_req_s)
  );

  // Accept/ready path; ready is held low while reset is asserted.
  always_comb begin
    can_load_s = rst && ((out_state_r == OUT_EMPTY) || glb_ready);
    xfer_s     = can_load_s && any_req_s;
    win_data_s = beat_s[gnt_idx_s][DATA_W-1:0];
    busy       = rst && ((out_state_r == OUT_FULL) || (|req_s));
    if (can_load_s) begin
      opsum_ready_bus = gnt_s;
    end else begin
      opsum_ready_bus = '0;
    end
    if (gnt_idx_s == COL_ID_W'(NUM_COL - 1)) begin
      ptr_nxt_s = '0;
    end else begin
      ptr_nxt_s = gnt_idx_s + COL_ID_W'(1);
    end
  end

  // Output register occupancy; a drain and a refill in one cycle stays FULL.
  always_comb begin
    out_state_nxt_s = out_state_r;
    case (out_state_r)
      OUT_EMPTY: begin
        if (xfer_s) out_state_nxt_s = OUT_FULL;
        else        out_state_nxt_s = OUT_EMPTY;
      end
      OUT_FULL: begin
        if (xfer_s)         out_state_nxt_s = OUT_FULL;
        else if (glb_ready) out_state_nxt_s = OUT_EMPTY;
        else                out_state_nxt_s = OUT_FULL;
      end
      default: out_state_nxt_s = OUT_EMPTY;
    endcase
  end

  // State registers; the mask load lands after this cycle's arbitration.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mask_r      <= '0;
      rr_ptr_r    <= '0;
      out_state_r <= OUT_EMPTY;
      glb_psum    <= '0;
      glb_col_id  <= '0;
    end else begin
      out_state_r <= out_state_nxt_s;
      if (set_info) begin
        mask_r <= col_mask;
      end
      if (xfer_s) begin
        glb_psum   <= {1'b1, win_data_s};
        glb_col_id <= gnt_idx_s;
        rr_ptr_r   <= ptr_nxt_s;
      end else if ((out_state_r == OUT_FULL) && glb_ready) begin
        glb_psum[EN_BIT] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_psum_bus_arbiter.sv
// Randomised and directed bench for psum_bus_arbiter against a behavioural
// model of the masked round-robin grant and one-entry output register.
module tb_psum_bus_arbiter;

  import pe_array_pkg::*;

  localparam int NC = 4;
  localparam int DW = PSUM_DATA_SIZE;
  localparam int ON = OPSUM_NUM;
  localparam int BW = psum_bus_w(ON, DW);
  localparam int IW = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              set_info = 1'b0;
  logic [NC-1:0]     col_mask = '0;
  logic [NC*BW-1:0]  opsum_bus = '0;
  logic [NC-1:0]     opsum_ready_bus;
  logic [BW-1:0]     glb_psum;
  logic [IW-1:0]     glb_col_id;
  logic              glb_ready = 1'b0;
  logic              busy;

  // reference model state
  logic [NC-1:0] m_mask = '0;
  int            m_ptr  = 0;
  bit            m_full = 1'b0;
  logic [BW-1:0] m_psum = '0;
  int            m_id   = 0;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  psum_bus_arbiter #(
    .NUM_COL        (NC),
    .PSUM_DATA_SIZE (DW),
    .OPSUM_NUM      (ON),
    .COL_ID_W       (IW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .set_info        (set_info),
    .col_mask        (col_mask),
    .opsum_bus       (opsum_bus),
    .opsum_ready_bus (opsum_ready_bus),
    .glb_psum        (glb_psum),
    .glb_col_id      (glb_col_id),
    .glb_ready       (glb_ready),
    .busy            (busy)
  );

  task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
  endtask

  // One clock: drive inputs, check ready/busy, advance model, check outputs.
  task automatic tick(input bit r, input bit s, input logic [NC-1:0] m,
                      input logic [NC-1:0] v, input bit g, input bit rnd);
    logic [BW-2:0] d [NC];
    logic [NC-1:0] exp_rdy;
    int            win;
    bit            can;
    @(negedge clk);
    rst = r; set_info = s; col_mask = m; glb_ready = g;
    for (int i = 0; i < NC; i++) begin
      for (int w = 0; w < ON; w++)
        d[i][w*DW +: DW] = rnd ? DW'($urandom) : DW'(32'h1111_1111 * 32'(i + 1));
      opsum_bus[i*BW +: BW] = {v[i], d[i]};
    end
    #1;
    can = !m_full || g;
    win = -1;
    for (int k = 0; k < NC; k++) begin
      int c;
      c = (m_ptr + k) % NC;
      if (win < 0 && v[c] && m_mask[c]) win = c;
    end
    exp_rdy = '0;
    if (r && can && win >= 0) exp_rdy[win] = 1'b1;
    check("opsum_ready_bus", BW'(opsum_ready_bus), BW'(exp_rdy));
    check("busy", BW'(busy), BW'(r && (m_full || (|(v & m_mask)))));
    @(posedge clk);
    if (!r) begin
      m_mask = '0; m_ptr = 0; m_full = 1'b0; m_psum = '0; m_id = 0;
    end else begin
      if (can && win >= 0) begin
        m_psum = {1'b1, d[win]};
        m_id   = win;
        m_ptr  = (win + 1) % NC;
        m_full = 1'b1;
      end else if (m_full && g) begin
        m_full = 1'b0;
        m_psum[BW-1] = 1'b0;
      end
      if (s) m_mask = m;
    end
    #1;
    check("glb_psum", glb_psum, m_psum);
    check("glb_col_id", BW'(glb_col_id), BW'(m_id));
    check("rr_ptr", BW'(dut.rr_ptr_r), BW'(m_ptr));
  endtask

  initial begin
    // reset, then full mask with all columns streaming
    tick(1'b0, 1'b0, 4'b0000, 4'b1111, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 4'b0000, 4'b1111, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 4'b1111, 4'b0000, 1'b1, 1'b0);
    repeat (10) tick(1'b1, 1'b0, 4'b0000, 4'b1111, 1'b1, 1'b0);
    // only columns 0 and 2 enabled
    tick(1'b1, 1'b1, 4'b0101, 4'b1111, 1'b1, 1'b0);
    repeat (8) tick(1'b1, 1'b0, 4'b0000, 4'b1111, 1'b1, 1'b1);
    // column 2 alone with a 5-cycle stall, then release
    tick(1'b1, 1'b1, 4'b1111, 4'b0000, 1'b1, 1'b0);
    repeat (2) tick(1'b1, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0);
    repeat (6) tick(1'b1, 1'b0, 4'b0000, 4'b0100, 1'b0, 1'b1);
    repeat (2) tick(1'b1, 1'b0, 4'b0000, 4'b0100, 1'b1, 1'b1);
    // column 3 alone with pointer at 3: wraps to 0
    tick(1'b1, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0);
    repeat (3) tick(1'b1, 1'b0, 4'b0000, 4'b1000, 1'b1, 1'b1);
    // reset while full and stalled; nothing granted until a new mask
    repeat (2) tick(1'b1, 1'b0, 4'b0000, 4'b1000, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 4'b0000, 4'b1000, 1'b0, 1'b1);
    repeat (3) tick(1'b1, 1'b0, 4'b0000, 4'b1111, 1'b1, 1'b1);
    // mask change coinciding with a column 1 transfer
    tick(1'b1, 1'b1, 4'b1111, 4'b0000, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 4'b0000, 4'b0001, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 4'b0001, 4'b0011, 1'b1, 1'b0);
    repeat (4) tick(1'b1, 1'b0, 4'b0000, 4'b1111, 1'b1, 1'b1);
    // randomised traffic
    repeat (400) begin
      tick(($urandom_range(0, 99) != 0), ($urandom_range(0, 9) == 0),
           NC'($urandom), NC'($urandom), ($urandom_range(0, 3) != 0), 1'b1);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/psum_bus_arbiter.md
# psum_bus_arbiter

- Shares one GLB psum write port among `NUM_COL` Local Network columns.
- Each column presents its `opsum_bus` (psum data plus enable); the block grants one column per beat in round-robin order.
- The granted beat goes into a one-entry output register that feeds the GLB with a valid/ready handshake.
- A per-column enable mask, loaded with `set_info`, excludes columns whose LNs are chained PE-to-PE and therefore never drive the bus.

## Interface
Parameters:
- `NUM_COL`, 4: number of LN columns (requesters), at least 2.
- `PSUM_DATA_SIZE`, 32: bits per psum.
- `OPSUM_NUM`, 4: psums per beat.
- `COL_ID_W`, `$clog2(NUM_COL)`: width of the source-column index.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: synchronous, active-low reset.
- `set_info`, in, 1: load strobe for `col_mask`.
- `col_mask`, in, `NUM_COL`: bit i = 1 means column i participates.
- `opsum_bus`, in, `NUM_COL*(OPSUM_NUM*PSUM_DATA_SIZE+1)`: column i occupies slice i.
  - Within a slice, the MSB is the enable (valid) bit and the lower bits are data.
- `opsum_ready_bus`, out, `NUM_COL`: per-column ready; bit i is the accept for column i.
- `glb_psum`, out, `OPSUM_NUM*PSUM_DATA_SIZE+1`: registered beat; MSB is valid.
- `glb_col_id`, out, `COL_ID_W`: source column of `glb_psum`.
- `glb_ready`, in, 1: GLB accepts `glb_psum` this cycle.
- `busy`, out, 1: output register full, or any enabled column has its valid bit set.

## Operation
Handshake and masking:
- Column i requests when its slice MSB is 1 and `mask_reg[i]` is 1. Masked columns never receive ready, and their valid bit is ignored.
- `mask_reg` loads `col_mask` on any cycle with `set_info` = 1, and otherwise holds.
- Mask changes take effect on the next arbitration cycle. A beat already in the output register is unaffected.

Output register and accept condition:
- The output register state is FULL or EMPTY.
- `can_load` = EMPTY, or (FULL and `glb_ready`). Draining and refilling can happen in the same cycle, so full throughput is one beat per cycle.

Arbitration:
- Round-robin pointer `rr_ptr`. Search starts at `rr_ptr` and wraps modulo `NUM_COL`; the first requesting column is the winner.
- `opsum_ready_bus[winner]` = `can_load`. All other bits are 0, and the whole vector is 0 when there are no requesters.
- Ready is combinational from the current requests, `can_load` and `rr_ptr`.

Transfer:
- A transfer occurs when ready and valid are both 1 for the winner.
- On transfer, the register loads the data with MSB = 1, `glb_col_id` = winner, and `rr_ptr` = winner+1, wrapping to 0 after `NUM_COL`-1.
- FULL with `glb_ready` = 1 and no transfer: the register goes EMPTY and `glb_psum` MSB goes to 0. Data bits hold their last value.
- FULL with `glb_ready` = 0: `glb_psum` and `glb_col_id` hold stable, no column is granted, and `rr_ptr` holds.
- `rr_ptr` never advances without a transfer, so a stalled or idle period causes no priority drift.

Boundary cases:
- Only one requester: it gets every beat at full rate.
- All columns masked: no grants are made; `busy` reflects only the output register.
- `set_info` coinciding with a transfer: the transfer uses the old mask.

Reset (`rst` = 0 at a clock edge), including mid-transfer:
- `glb_psum` = 0 (valid 0), `glb_col_id` = 0, `rr_ptr` = 0, `mask_reg` = 0.
- The output register goes EMPTY and any held beat is dropped.
- `opsum_ready_bus` = 0 while in reset and after reset, because the mask is 0.
- `busy` = 0.

## Timing
- Latency is 1 cycle from column transfer to `glb_psum` valid.
- Sustained throughput is 1 beat per cycle when `glb_ready` stays high.
- Fairness: with all columns requesting continuously, each column wins exactly once in any `NUM_COL` consecutive transfers.
- The maximum wait for a requesting, unmasked column is `NUM_COL`-1 transfers.
- `glb_psum` and `glb_col_id` are driven straight from flops.
- `opsum_ready_bus` is combinational, depending on `glb_ready` through `can_load`. The ready path is the critical path to watch.

## Structure
- Package `pe_array_pkg`:
  - `PSUM_DATA_SIZE` and `OPSUM_NUM` defaults.
  - Function `psum_bus_w(opsum_num, data_size)` returning `opsum_num*data_size+1`.
  - Constant "enable bit is MSB of a psum bus beat", shared with LN.
- Sub-module `rr_arbiter` (parameter `N`):
  - Inputs: `req[N]`, `ptr`.
  - Outputs: one-hot `gnt[N]`, `gnt_idx`, `any_req`.
  - Purely combinational; `rr_ptr` stays in the parent.
- The parent holds `mask_reg`, `rr_ptr`, the output register and the handshake logic.

## Test plan
- Reset then mask = 4'b1111; all four columns valid with data 0x1..,0x2..,0x3..,0x4..; `glb_ready` = 1. Required: `glb_col_id` sequence 0,1,2,3,0,… with one beat per cycle and matching data.
- Mask = 4'b0101, all columns valid. Required: only columns 0 and 2 are granted, alternating; `opsum_ready_bus[1]` and `opsum_ready_bus[3]` are never 1.
- Column 2 valid, `glb_ready` = 0 for 5 cycles. Required: one transfer, then `glb_psum` stable for 5 cycles, `opsum_ready_bus` = 0 and `rr_ptr` = 3. On release, the beat drains and the next beat loads in the same cycle.
- Column 3 holds the only request with `rr_ptr` = 3. Required: the grant goes to 3 and `rr_ptr` wraps to 0.
- `rst` = 0 asserted while FULL and stalled. Required: next cycle `glb_psum` = 0, `busy` = 0 and `opsum_ready_bus` = 0 until a new mask is loaded.
- `set_info` with mask 4'b0001 in the same cycle that column 1 transfers. Required: the column 1 beat appears on `glb_psum`; afterwards only column 0 is granted.
